// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores, lane extract/extension for loads
module lsu_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_data,
  output logic        legal
);

  logic [31:0] shifted;
  logic        f3_ok;
  logic        aligned;

  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (funct3)
      F3_B:  f3_ok = 1'b1;
      F3_H:  begin f3_ok = 1'b1; aligned = ~addr_lo[0]; end
      F3_W:  begin f3_ok = 1'b1; aligned = (addr_lo == 2'b00); end
      F3_BU: f3_ok = ~we;
      F3_HU: begin f3_ok = ~we; aligned = ~addr_lo[0]; end
      default: f3_ok = 1'b0;
    endcase
    legal = f3_ok & aligned;
  end

  // Store data is replicated across lanes; the mask picks the lanes that land.
  always_comb begin
    wmask    = 4'b0000;
    wdata_sh = wdata;
    if (legal && we) begin
      case (funct3)
        F3_B: begin
          wmask    = 4'b0001 << addr_lo;
          wdata_sh = {4{wdata[7:0]}};
        end
        F3_H: begin
          wmask    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_sh = {2{wdata[15:0]}};
        end
        default: begin
          wmask    = 4'b1111;
          wdata_sh = wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = rdata_word >> {addr_lo, 3'b000};
    load_data = 32'h0;
    case (funct3)
      F3_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:  load_data = rdata_word;
      F3_BU: load_data = {24'h0, shifted[7:0]};
      F3_HU: load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed programmable latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm0
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t           state;
  state_t           state_nxt;
  logic [LAT_W-1:0] cnt;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [2:0]       lat_funct3;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [AW-1:0]    word_idx;
  logic             in_range;
  logic             legal;
  logic             acc_err;
  logic [3:0]       wmask;
  logic [31:0]      wdata_sh;
  logic [31:0]      load_data;
  logic             access;

  assign word_idx = lat_addr[AW+1:2];
  assign in_range = (lat_addr[31:2] < 30'(DEPTH_WORDS));
  assign acc_err  = ~legal | ~in_range;
  assign access   = (state == ST_BUSY) && (cnt == LAT_W'(1));

  lsu_align u_align (
    .we        (lat_we),
    .addr_lo   (lat_addr[1:0]),
    .funct3    (lat_funct3),
    .wdata     (lat_wdata),
    .rdata_word(mem[word_idx]),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .load_data (load_data),
    .legal     (legal)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == LAT_W'(1)) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        lat_we     <= req_we;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_funct3 <= req_funct3;
        cnt        <= LAT_W'(LATENCY);
      end else if (state == ST_BUSY) begin
        cnt <= cnt - LAT_W'(1);
      end
      if (access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || lat_we) ? 32'h0 : load_data;
      end
    end
  end

  // Memory is cleared by reset, so a store caught mid-flight never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (access && !acc_err && lat_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_valid = (state == ST_RESP) && !rst;
  assign dm0       = mem[0];

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dm0       (dm0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) check("rsp_valid_timeout", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                      output int lat);
    issue(we, addr, wdata, f3);
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_dm0;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    check("rst_dm0",       dm0, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    xact(1'b1, 32'h0, 32'hDEADBEEF, 3'b010, rd, er, lat);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_err",     {31'b0, er}, 32'd0);
    check("sw_rdata",   rd, 32'h0);
    check("sw_dm0",     dm0, 32'hDEADBEEF);
    check("sw_req_ready_after_hs", {31'b0, req_ready}, 32'd1);

    vecs.push_back('{"lb_3",      1'b0, 32'h3,   32'h0,  3'b000, 32'hFFFFFFDE, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"lbu_3",     1'b0, 32'h3,   32'h0,  3'b100, 32'h000000DE, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"lh_2",      1'b0, 32'h2,   32'h0,  3'b001, 32'hFFFFDEAD, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"lhu_0",     1'b0, 32'h0,   32'h0,  3'b101, 32'h0000BEEF, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{"sb_1",      1'b1, 32'h1,   32'h12, 3'b000, 32'h0,        1'b0, 32'hDEAD12EF});
    vecs.push_back('{"lw_0",      1'b0, 32'h0,   32'h0,  3'b010, 32'hDEAD12EF, 1'b0, 32'hDEAD12EF});
    vecs.push_back('{"lw_mis",    1'b0, 32'h2,   32'h0,  3'b010, 32'h0,        1'b1, 32'hDEAD12EF});
    vecs.push_back('{"sh_mis",    1'b1, 32'h1,   32'hFFFF, 3'b001, 32'h0,      1'b1, 32'hDEAD12EF});
    vecs.push_back('{"ld_f3_011", 1'b0, 32'h0,   32'h0,  3'b011, 32'h0,        1'b1, 32'hDEAD12EF});
    vecs.push_back('{"st_f3_100", 1'b1, 32'h0,   32'h0,  3'b100, 32'h0,        1'b1, 32'hDEAD12EF});
    vecs.push_back('{"lw_oor",    1'b0, 32'h400, 32'h0,  3'b010, 32'h0,        1'b1, 32'hDEAD12EF});
    vecs.push_back('{"sw_oor",    1'b1, 32'h400, 32'h0,  3'b010, 32'h0,        1'b1, 32'hDEAD12EF});

    foreach (vecs[i]) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, rd, er, lat);
      check({vecs[i].tag, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].tag, "_err"},   {31'b0, er}, {31'b0, vecs[i].exp_err});
      check({vecs[i].tag, "_dm0"},   dm0, vecs[i].exp_dm0);
    end

    // Back-pressured response with a second request waiting.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0, 32'h0, 3'b010);
    wait_rsp(lat);
    check("hold_latency", 32'(lat), 32'd2);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2; req_funct3 = 3'b101;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEAD12EF);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 check("hold_idle_after_hs", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat);
    check("second_latency", 32'(lat), 32'd2);
    check("second_rdata",   rsp_rdata, 32'h0000DEAD);
    @(posedge clk);
    #1;

    // Reset while a store is in flight.
    issue(1'b1, 32'h4, 32'h55, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) lat++;
    end
    check("rst_busy_no_rsp", 32'(lat), 32'd0);
    check("rst_busy_dm0",    dm0, 32'h0);
    xact(1'b0, 32'h4, 32'h0, 3'b010, rd, er, lat);
    check("rst_busy_lw4",     rd, 32'h0);
    check("rst_busy_lw4_err", {31'b0, er}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
